// File: rtl/lpc_preemphasis.sv
// Streaming pre-emphasis y[n] = x[n] - a*x[n-1] between the DDR3 read
// and write masters, with a small output FIFO to ride out write backpressure.
module lpc_preemphasis #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           frame_length,
  input  logic [DATA_WIDTH-1:0] coef,
  output logic                  done,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_available,
  output logic                  in_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_write,
  input  logic                  out_full
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [31:0]          rd_rem_q, rd_rem_d;
  logic [31:0]          wr_rem_q, wr_rem_d;
  logic signed [DW-1:0] coef_q, coef_d;
  logic signed [DW-1:0] x_prev_q, x_prev_d;
  logic signed [DW-1:0] stg_x_q;
  logic signed [PW-1:0] stg_p_q;
  logic                 stg_v_q;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q;

  logic [CW:0]          occ;
  logic signed [PW-1:0] prod;
  logic signed [DW+1:0] p_sh;
  logic signed [DW+1:0] y_w;
  logic [DW-1:0]        y_sat;

  // Stage entry counts as occupied so a pop always has a FIFO slot waiting
  assign occ = {1'b0, cnt_q} + {{CW{1'b0}}, stg_v_q};

  assign in_read = (state_q == RUN) && in_data_available
                && (rd_rem_q != '0)
                && (occ < (CW+1)'(FIFO_DEPTH));

  assign out_write = (cnt_q != '0) && !out_full;
  assign out_data  = mem_q[rp_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FLUSH) && (wr_rem_q == '0)
                  && !stg_v_q && (cnt_q == '0);

  assign prod = PW'(coef_q) * PW'(x_prev_q);
  assign p_sh = (DW+2)'(stg_p_q >>> (DW-1));
  assign y_w  = (DW+2)'(stg_x_q) - p_sh;

  always_comb begin
    y_sat = y_w[DW-1:0];
    if (!((y_w[DW+1:DW-1] == 3'b000) || (y_w[DW+1:DW-1] == 3'b111))) begin
      y_sat = y_w[DW+1] ? {1'b1, {(DW-1){1'b0}}}
                        : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_rem_d = rd_rem_q;
    wr_rem_d = wr_rem_q;
    coef_d   = coef_q;
    x_prev_d = x_prev_q;
    if (in_read) begin
      rd_rem_d = rd_rem_q - 32'd1;
      x_prev_d = in_data;
    end
    if (out_write && (wr_rem_q != '0)) begin
      wr_rem_d = wr_rem_q - 32'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          coef_d   = coef;
          x_prev_d = '0;
          rd_rem_d = frame_length;
          wr_rem_d = frame_length;
          state_d  = (frame_length == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (in_read && (rd_rem_q == 32'd1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_rem_q <= '0;
      wr_rem_q <= '0;
      coef_q   <= '0;
      x_prev_q <= '0;
      stg_x_q  <= '0;
      stg_p_q  <= '0;
      stg_v_q  <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_rem_q <= rd_rem_d;
      wr_rem_q <= wr_rem_d;
      coef_q   <= coef_d;
      x_prev_q <= x_prev_d;
      stg_v_q  <= in_read;
      if (in_read) begin
        stg_x_q <= in_data;
        stg_p_q <= prod;
      end
      if (stg_v_q) begin
        mem_q[wp_q] <= y_sat;
        wp_q        <= wp_q + AW'(1);
      end
      if (out_write) rp_q <= rp_q + AW'(1);
      unique case ({stg_v_q, out_write})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_preemphasis.sv
// Directed bench for lpc_preemphasis: arithmetic reference model,
// show-ahead source model and a per-cycle output checker.
module tb_lpc_preemphasis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] frame_length = '0;
  logic [15:0] coef = '0;
  logic        done, busy, in_read, out_write;
  logic [15:0] in_data = '0;
  logic        in_data_available = 1'b0;
  logic [15:0] out_data;
  logic        out_full = 1'b0;

  always #5 clk = ~clk;

  lpc_preemphasis #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_length(frame_length), .coef(coef),
    .done(done), .busy(busy),
    .in_data(in_data), .in_data_available(in_data_available),
    .in_read(in_read),
    .out_data(out_data), .out_write(out_write), .out_full(out_full)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] src [512];
  int          n_src = 0;
  int          idx = 0;
  bit          rd_pend = 1'b0;
  int          full_mode = 0;
  int          drv_cyc = 0;
  int          bp_base = 0;

  logic [15:0] exp_q [$];
  logic [15:0] got [$];

  int cyc = 0, done_cnt = 0, done_cyc = -1;
  int wr_cnt = 0, rd_cnt = 0, first_rd = -1, first_wr = -1, last_wr = -1;
  int start_cyc = -1, run_len = 0, max_run = 0;
  int viol_full = 0, viol_avail = 0;
  int d0 = 0, wr0 = 0, rd0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] ref_y(input logic [15:0] x,
                                        input logic [15:0] xp,
                                        input logic [15:0] a);
    longint p, y;
    p = longint'($signed(a)) * longint'($signed(xp));
    y = longint'($signed(x)) - (p >>> 15);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  // Show-ahead read master: head advances one edge after a sampled pop
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) idx++;
      drv_cyc++;
      in_data_available = (idx < n_src);
      in_data = (idx < n_src) ? src[idx] : 16'h0;
      out_full = (full_mode != 0)
              && (((drv_cyc - bp_base) inside {[3:12]})
                  || ($urandom_range(0, 1) == 1));
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (start && !busy && !rst) start_cyc = cyc;
    if (in_read) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      run_len++;
      if (!in_data_available) viol_avail++;
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
    rd_pend = in_read;
    if (out_write) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      got.push_back(out_data);
      if (out_full) viol_full++;
      if (exp_q.size() == 0) chk("extra_write", out_data, 64'hDEAD);
      else chk("sample", out_data, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_frame(input int n, input logic [15:0] c);
    exp_q.delete();
    got.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back(ref_y(src[i], (i == 0) ? 16'h0 : src[i-1], c));
    idx = 0;
    n_src = n;
    d0 = done_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    first_rd = -1; first_wr = -1; max_run = 0;
    @(posedge clk); #1;
    start = 1'b1; frame_length = n; coef = c;
    @(posedge clk); #1;
    start = 1'b0; frame_length = '0; coef = '0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (4) @(posedge clk);
    chk("one_done", done_cnt - d0, 1);
    chk("writes", wr_cnt - wr0, n);
    chk("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_read", in_read, 0);
    chk("rst_out_write", out_write, 0);
    chk("rst_out_data", out_data, 0);

    chk("model_imp", ref_y(16'h0000, 16'h1000, 16'h4000), 16'hF800);
    chk("model_sat", ref_y(16'h7FFF, 16'h8000, 16'h7FFF), 16'h7FFF);
    chk("model_floor", ref_y(16'h0000, 16'hFFFF, 16'h4000), 16'h0001);

    // impulse
    src[0] = 16'h1000; src[1] = 16'h0; src[2] = 16'h0; src[3] = 16'h0;
    start_frame(4, 16'h4000);
    wait_done(4, 100);
    chk("imp0", got[0], 16'h1000);
    chk("imp1", got[1], 16'hF800);
    chk("imp2", got[2], 16'h0000);
    chk("imp3", got[3], 16'h0000);

    // positive saturation
    src[0] = 16'h8000; src[1] = 16'h7FFF;
    start_frame(2, 16'h7FFF);
    wait_done(2, 100);
    chk("sat0", got[0], 16'h8000);
    chk("sat1", got[1], 16'h7FFF);

    // negative saturation and floor rounding
    src[0] = 16'h7FFF; src[1] = 16'h8000; src[2] = 16'hFFFF; src[3] = 16'h0000;
    start_frame(4, 16'h7FFF);
    wait_done(4, 100);
    chk("nsat1", got[1], 16'h8000);
    src[0] = 16'hFFFF; src[1] = 16'h0000;
    start_frame(2, 16'h4000);
    wait_done(2, 100);
    chk("floor1", got[1], 16'h0001);

    // backpressure on a ramp
    for (int i = 0; i < 16; i++) src[i] = 16'(i * 2000 - 16000);
    full_mode = 1;
    bp_base = drv_cyc;
    start_frame(16, 16'h6000);
    wait_done(16, 600);
    full_mode = 0;
    chk("no_write_when_full", viol_full, 0);

    // zero length
    start_frame(0, 16'h1234);
    wait_done(0, 20);
    chk("zero_done_cyc", done_cyc - start_cyc, 1);
    chk("zero_no_read", rd_cnt - rd0, 0);

    // ignored start while busy
    for (int i = 0; i < 512; i++) src[i] = 16'(i * 613 + 16'h8100);
    start_frame(512, 16'h3000);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; frame_length = 3; coef = 16'h7FFF;
    @(posedge clk); #1 start = 1'b0; frame_length = '0; coef = '0;
    wait_done(512, 2000);

    // full-rate streaming
    start_frame(512, 16'hA000);
    wait_done(512, 2000);
    chk("run_512", max_run, 512);
    chk("first_latency", first_wr - first_rd, 2);
    chk("done_from_read", done_cyc - first_rd, 514);
    chk("done_after_last_wr", done_cyc - last_wr, 1);

    // reset mid-frame
    start_frame(512, 16'h5000);
    for (int k = 0; k < 1000 && (rd_cnt - rd0) < 100; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_in_read", in_read, 0);
    chk("mid_out_write", out_write, 0);
    chk("mid_out_data", out_data, 0);
    repeat (6) @(posedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    src[0] = 16'h1234;
    for (int i = 1; i < 8; i++) src[i] = 16'(i * 4111);
    start_frame(8, 16'h7000);
    wait_done(8, 100);
    chk("first_after_rst", got[0], 16'h1234);

    chk("read_only_when_avail", viol_avail, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
